oam_dma: RTL and testbench

OAM DMA engine: the bus-initiator counterpart of the LCD register block's DMA register at FF46. A CPU write to FF46 raises `dma_start` and updates `dma_src`. The engine then copies 160 bytes from `{dma_src, 8'h00}`–`{dma_src, 8'h9F}` into OAM (FE00–FE9F), one byte every `BYTE_CYCLES` clocks. It asserts `dma_active` so the bus arbiter can block CPU access for the duration.

---
 rtl/oam_dma.sv | 172 +++++++++++++++++
 tb/tb_oam_dma.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Purpose  : OAM DMA engine. When the FF46 register sees a write, this block
//            copies 160 bytes from {dma_src, 8'h00..8'h9F} into OAM
//            (FE00..FE9F). It moves one byte every BYTE_CYCLES clocks and
//            holds dma_active high so the bus arbiter can block the CPU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1   system clock, rising edge
//   nreset       in   1   synchronous reset, active-high
//   dma_src      in   8   source page (high address byte) from FF46
//   dma_start    in   1   level, high while the CPU writes FF46
//   dma_rdata    in   8   source read data (zero-wait)
//   dma_address  out  16  source read address
//   dma_nread    out  1   active-low source read strobe
//   oam_address  out  8   OAM byte index 0..159
//   oam_data     out  8   OAM write data
//   oam_nwrite   out  1   active-low OAM write strobe
//   dma_active   out  1   transfer in progress (START or XFER)
//   dma_done     out  1   one-cycle pulse after a normal completion
// Parameters
//   BYTE_CYCLES  clocks per transferred byte, legal range 2..15
// ============================================================================
module oam_dma #(
  parameter int BYTE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [7:0]  dma_src,
  input  logic        dma_start,
  input  logic [7:0]  dma_rdata,
  output logic [15:0] dma_address,
  output logic        dma_nread,
  output logic [7:0]  oam_address,
  output logic [7:0]  oam_data,
  output logic        oam_nwrite,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  localparam logic [3:0] PHASE_LAST = 4'(BYTE_CYCLES - 1);
  localparam logic [7:0] IDX_LAST   = 8'd159;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  phase_q, phase_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;

  // Output flops. They are loaded from the next-state values so that each
  // output is aligned with the state it decodes, with no input-to-output path.
  logic [15:0] dma_address_q, dma_address_d;
  logic        dma_nread_q, dma_nread_d;
  logic [7:0]  oam_address_q, oam_address_d;
  logic [7:0]  oam_data_q, oam_data_d;
  logic        oam_nwrite_q, oam_nwrite_d;
  logic        active_q, active_d;

  logic        start_edge;
  logic        read_next;
  logic        write_next;

  assign start_edge = dma_start & ~start_q;

  always_comb begin
    state_d = state_q;
    start_d = dma_start;
    src_d   = src_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_START;
      end
      S_START: begin
        // FF46 has been written by now, so the page is stable here.
        src_d   = dma_src;
        idx_d   = 8'd0;
        phase_d = 4'd0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (phase_q == 4'd0) data_d = dma_rdata;
        if (phase_q == PHASE_LAST) begin
          phase_d = 4'd0;
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh FF46 write restarts from scratch. The strobes of this cycle
    // still complete, but the aborted transfer never reports done.
    if (start_edge && state_q != S_IDLE) begin
      state_d = S_START;
      done_d  = 1'b0;
    end

    read_next  = (state_d == S_XFER) && (phase_d == 4'd0);
    write_next = (state_d == S_XFER) && (phase_d == PHASE_LAST);

    dma_address_d = read_next  ? {src_d, idx_d} : 16'h0000;
    dma_nread_d   = ~read_next;
    oam_address_d = write_next ? idx_d  : 8'h00;
    oam_data_d    = write_next ? data_d : 8'h00;
    oam_nwrite_d  = ~write_next;
    active_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      state_q       <= S_IDLE;
      // Held at 1 so a dma_start level present across reset cannot trigger.
      start_q       <= 1'b1;
      src_q         <= 8'h00;
      idx_q         <= 8'h00;
      phase_q       <= 4'd0;
      data_q        <= 8'h00;
      done_q        <= 1'b0;
      dma_address_q <= 16'h0000;
      dma_nread_q   <= 1'b1;
      oam_address_q <= 8'h00;
      oam_data_q    <= 8'h00;
      oam_nwrite_q  <= 1'b1;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      src_q         <= src_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      data_q        <= data_d;
      done_q        <= done_d;
      dma_address_q <= dma_address_d;
      dma_nread_q   <= dma_nread_d;
      oam_address_q <= oam_address_d;
      oam_data_q    <= oam_data_d;
      oam_nwrite_q  <= oam_nwrite_d;
      active_q      <= active_d;
    end
  end

  assign dma_address = dma_address_q;
  assign dma_nread   = dma_nread_q;
  assign oam_address = oam_address_q;
  assign oam_data    = oam_data_q;
  assign oam_nwrite  = oam_nwrite_q;
  assign dma_active  = active_q;
  assign dma_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma
// Purpose  : Self-checking bench for oam_dma. Two instances (4 and 2 clocks
//            per byte) share one stimulus stream. Each cycle, every output is
//            compared with a reference model. The model tracks the cycle
//            offset from the START cycle and derives the byte number and
//            phase arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma;

  logic        clock = 1'b0;
  logic        nreset;
  logic [7:0]  dma_src;
  logic        dma_start;

  logic [15:0] a4, a2;
  logic        nr4, nr2, nw4, nw2, act4, act2, dn4, dn2;
  logic [7:0]  oa4, oa2, od4, od2;
  logic [7:0]  rd4, rd2;

  logic [7:0]  mem [65536];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign rd4 = mem[a4];
  assign rd2 = mem[a2];

  oam_dma #(.BYTE_CYCLES(4)) dut4 (
    .clock(clock), .nreset(nreset), .dma_src(dma_src), .dma_start(dma_start),
    .dma_rdata(rd4), .dma_address(a4), .dma_nread(nr4), .oam_address(oa4),
    .oam_data(od4), .oam_nwrite(nw4), .dma_active(act4), .dma_done(dn4)
  );

  oam_dma #(.BYTE_CYCLES(2)) dut2 (
    .clock(clock), .nreset(nreset), .dma_src(dma_src), .dma_start(dma_start),
    .dma_rdata(rd2), .dma_address(a2), .dma_nread(nr2), .oam_address(oa2),
    .oam_data(od2), .oam_nwrite(nw2), .dma_active(act2), .dma_done(dn2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. m_d = cycle offset from START (0 = START), -1 = idle.
  int         m_d    [2] = '{-1, -1};
  logic [7:0] m_src  [2] = '{8'h00, 8'h00};
  bit         m_done [2] = '{1'b0, 1'b0};
  bit         m_start_q  = 1'b1;
  bit         en         = 1'b0;
  int         bv     [2] = '{4, 2};

  always @(negedge clock) begin
    bit edge_s;
    edge_s = dma_start && !m_start_q;
    for (int i = 0; i < 2; i++) begin
      int b, d, k, p;
      logic [15:0] ea;
      logic [7:0]  eoa, eod;
      bit          enr, enw;
      b = bv[i];
      d = m_d[i];
      if (en) begin
        ea = 16'h0; enr = 1'b1; eoa = 8'h0; eod = 8'h0; enw = 1'b1;
        if (d >= 1) begin
          k = (d - 1) / b;
          p = (d - 1) % b;
          if (p == 0) begin
            ea  = {m_src[i], 8'(k)};
            enr = 1'b0;
          end
          if (p == b - 1) begin
            eoa = 8'(k);
            eod = mem[{m_src[i], 8'(k)}];
            enw = 1'b0;
          end
        end
        check($sformatf("B%0d dma_address", b), int'(i == 0 ? a4 : a2), int'(ea));
        check($sformatf("B%0d dma_nread", b), int'(i == 0 ? nr4 : nr2), int'(enr));
        check($sformatf("B%0d oam_address", b), int'(i == 0 ? oa4 : oa2), int'(eoa));
        check($sformatf("B%0d oam_data", b), int'(i == 0 ? od4 : od2), int'(eod));
        check($sformatf("B%0d oam_nwrite", b), int'(i == 0 ? nw4 : nw2), int'(enw));
        check($sformatf("B%0d dma_active", b), int'(i == 0 ? act4 : act2), int'(d >= 0));
        check($sformatf("B%0d dma_done", b), int'(i == 0 ? dn4 : dn2), int'(m_done[i]));
      end
      // Advance the model to the next cycle.
      if (nreset) begin
        m_d[i]    = -1;
        m_done[i] = 1'b0;
        m_src[i]  = 8'h00;
      end else begin
        if (d == 0) m_src[i] = dma_src;
        m_done[i] = (d == 160 * b) && !edge_s;
        if (edge_s)                      m_d[i] = 0;
        else if (d < 0 || d == 160 * b)  m_d[i] = -1;
        else                             m_d[i] = d + 1;
      end
    end
    m_start_q = nreset ? 1'b1 : dma_start;
    if (nreset) en = 1'b1;
  end

  // Drive one cycle's worth of inputs, then advance past the rising edge.
  task automatic cyc(input logic s, input logic [7:0] src, input logic r);
    nreset    = r;
    dma_start = s;
    dma_src   = src;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  // One-cycle start pulse; the page is held into the START cycle.
  task automatic pulse(input logic [7:0] src);
    cyc(1'b1, src, 1'b0);
    cyc(1'b0, src, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    nreset = 1'b1; dma_start = 1'b0; dma_src = 8'h00;

    // Start held high across reset release: no transfer until low then high.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55, 1'b0);
    idle(10);

    // Basic transfer from page C1.
    pulse(8'hC1);
    idle(660);

    // Start held for five cycles: one transfer only.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h3A, 1'b0);
    idle(660);

    // Restart around idx 50: new edge with 0x80, page changes to D0 in START.
    pulse(8'h12);
    idle(200);
    cyc(1'b1, 8'h80, 1'b0);
    cyc(1'b0, 8'hD0, 1'b0);
    idle(660);

    // Reset around idx 100, then a full transfer.
    pulse(8'h47);
    idle(400);
    cyc(1'b0, 8'h00, 1'b1);
    idle(20);
    pulse(8'h9E);
    idle(660);

    // Page FF (no mirroring).
    pulse(8'hFF);
    idle(660);

    // Start edge exactly on the final write cycle of the 4-cycle instance.
    cyc(1'b1, 8'h21, 1'b0);
    idle(640);
    cyc(1'b1, 8'h63, 1'b0);
    idle(660);

    // Reset and start edge together: reset wins.
    cyc(1'b1, 8'h77, 1'b1);
    idle(20);

    // Random traffic with occasional restarts and resets.
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 299) == 0), 8'($urandom), ($urandom_range(0, 1499) == 0));
    idle(700);

    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
